// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: buffers incoming audio samples in a small FIFO and
// sequences each one through an external FIR filter or around it (bypass).
// Filter results are rounded, scaled by gain and saturated to 8 bits.
//
// Handshake semantics: every strobe here (ready, fir_start, fir_done,
// out_valid) is a one-cycle qualifier with no back-pressure. A payload is
// valid only in a cycle where its strobe is 1. A sample strobed in while the
// FIFO is full is dropped and counted. fir_done is honoured only in WAIT.
module fir_sample_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic signed [7:0] x,
  input  logic              bypass,
  input  logic [1:0]        gain,
  output logic              fir_start,
  output logic signed [7:0] fir_x,
  input  logic signed [17:0] fir_y,
  input  logic              fir_done,
  output logic              out_valid,
  output logic signed [7:0] out_sample,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err,
  output logic [7:0]        drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state;

  // FIFO storage and bookkeeping
  logic signed [7:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;
  logic signed [7:0] head;

  // Watchdog counter for the WAIT state
  logic [WW-1:0]     wd_cnt;

  // Scaling datapath
  logic [3:0]         shift_amt;
  logic signed [18:0] round_term;
  logic signed [18:0] sum;
  logic signed [18:0] shifted;
  logic signed [7:0]  scaled;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign head       = mem[rd_ptr];

  // The FSM only consumes from the FIFO while idle; a pop frees a slot for a
  // push arriving in the same cycle, so a full FIFO does not drop it.
  assign pop  = (state == IDLE) && !fifo_empty;
  assign push = ready && (!fifo_full || pop);
  assign drop = ready && fifo_full && !pop;

  assign busy = (state != IDLE) || !fifo_empty;

  // Round-half-up then arithmetic shift by 10-gain, saturated to 8 bits
  always_comb begin
    shift_amt  = 4'd10 - {2'b00, gain};
    round_term = 19'sd1 <<< (shift_amt - 4'd1);
    sum        = {fir_y[17], fir_y} + round_term;
    shifted    = sum >>> shift_amt;
    if (shifted > 19'sd127) begin
      scaled = 8'sd127;
    end else if (shifted < -19'sd128) begin
      scaled = -8'sd128;
    end else begin
      scaled = shifted[7:0];
    end
  end

  // FIFO storage write; contents need no reset since count gates reads
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= x;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun flag and saturating drop counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Sequencing FSM with registered strobes and data outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fir_start   <= 1'b0;
      fir_x       <= 8'sd0;
      out_valid   <= 1'b0;
      out_sample  <= 8'sd0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      fir_start <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (bypass) begin
              out_sample <= head;
              out_valid  <= 1'b1;
            end else begin
              fir_x     <= head;
              fir_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (fir_done) begin
            out_sample <= scaled;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            out_sample  <= 8'sd0;
            out_valid   <= 1'b1;
            state       <= OUT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed testbench for fir_sample_sequencer with a behavioural filter model
// and an expected-output scoreboard.
module tb_fir_sample_sequencer;

  logic              clock;
  logic              reset;
  logic              ready;
  logic [7:0]        x;
  logic              bypass;
  logic [1:0]        gain;
  logic              fir_start;
  logic [7:0]        fir_x;
  logic [17:0]       fir_y;
  logic              fir_done;
  logic              out_valid;
  logic [7:0]        out_sample;
  logic              busy;
  logic              overrun;
  logic              timeout_err;
  logic [7:0]        drop_count;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Scoreboard queues
  logic [7:0]  exp_q[$];
  logic [7:0]  fx_q[$];
  logic [17:0] y_q[$];

  // Filter model controls and observations
  int fir_delay   = 33;
  bit fir_silent  = 0;
  int done_cyc    = -1;
  int start_cyc   = -1;
  int start_count = 0;
  int out_count   = 0;
  int last_out_cyc = -1;

  fir_sample_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .ready       (ready),
    .x           (x),
    .bypass      (bypass),
    .gain        (gain),
    .fir_start   (fir_start),
    .fir_x       (fir_x),
    .fir_y       (fir_y),
    .fir_done    (fir_done),
    .out_valid   (out_valid),
    .out_sample  (out_sample),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .drop_count  (drop_count)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] scale(input int y, input int g);
    int s;
    int t;
    logic [31:0] tv;
    s = 10 - g;
    t = (y + (1 << (s - 1))) >>> s;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    tv = t;
    return tv[7:0];
  endfunction

  // Behavioural filter: answers each start after fir_delay cycles
  initial begin
    fir_done = 1'b0;
    fir_y    = '0;
    forever begin
      @(negedge clock);
      if (fir_start === 1'b1 && reset === 1'b0) begin
        logic [17:0] y;
        y = (y_q.size() > 0) ? y_q.pop_front() : 18'd0;
        if (!fir_silent) begin
          repeat (fir_delay) @(negedge clock);
          fir_y    = y;
          fir_done = 1'b1;
          done_cyc = cyc;
          @(negedge clock);
          fir_done = 1'b0;
        end
      end
    end
  end

  // Start monitor: fir_x at each start must follow FIFO order
  always @(negedge clock) begin
    if (fir_start === 1'b1) begin
      start_count++;
      start_cyc = cyc;
      check("fx_q_nonempty", fx_q.size() != 0, 1);
      if (fx_q.size() != 0) check("fir_x", fir_x, fx_q.pop_front());
    end
  end

  // Output monitor: pop and compare expected samples in order
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      out_count++;
      last_out_cyc = cyc;
      check("exp_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("out_sample", out_sample, exp_q.pop_front());
    end
  end

  task automatic drive_one(input logic [7:0] v, output int n);
    @(negedge clock);
    ready = 1'b1;
    x     = v;
    n     = cyc;
    @(negedge clock);
    ready = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int target;
    target = out_count + n;
    for (int i = 0; i < budget && out_count < target; i++) @(negedge clock);
    check("wait_outputs", out_count >= target, 1);
  endtask

  task automatic run_filter(input logic [7:0] v, input int y, input int g);
    int n;
    logic [17:0] yv;
    yv = y;
    fx_q.push_back(v);
    y_q.push_back(yv);
    exp_q.push_back(scale(y, g));
    drive_one(v, n);
    wait_outputs(1, 200);
  endtask

  // Directed stimulus sequence
  initial begin
    int n;
    int starts0;
    int outs0;
    reset  = 1'b1;
    ready  = 1'b0;
    x      = '0;
    bypass = 1'b0;
    gain   = 2'd2;

    // Reset state
    #3;
    check("rst_fir_start", fir_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_count", drop_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single sample: x=100, gain=2, fir_y=25600 after 33 cycles
    fir_delay = 33;
    fx_q.push_back(8'd100);
    y_q.push_back(18'd25600);
    exp_q.push_back(scale(25600, 2));
    drive_one(8'd100, n);
    check("start_n1", fir_start, 0);
    check("busy_n1", busy, 1);
    @(negedge clock);
    check("start_n2", fir_start, 1);
    check("start_cyc", cyc, n + 2);
    @(negedge clock);
    check("start_n3", fir_start, 0);
    check("fir_x_hold", fir_x, 100);
    wait_outputs(1, 200);
    check("out_after_done", last_out_cyc, done_cyc + 1);
    check("done_delay", done_cyc, start_cyc + 33);
    check("single_value_100", scale(25600, 2), 100);

    // Saturation at gain=3
    gain = 2'd3;
    fir_delay = 5;
    run_filter(8'd1, 131071, 3);
    run_filter(8'd2, -131072, 3);
    repeat (3) @(negedge clock);

    // Burst: six strobes back to back, sixth dropped
    gain = 2'd2;
    fir_delay = 10;
    check("overrun_pre", overrun, 0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] v;
      logic [17:0] yv;
      v = 8'(i * 17 - 40);
      yv = 18'($signed(v) * 256);
      if (i < 5) begin
        fx_q.push_back(v);
        y_q.push_back(yv);
        exp_q.push_back(scale($signed(v) * 256, 2));
      end
      @(negedge clock);
      ready = 1'b1;
      x     = v;
    end
    @(negedge clock);
    ready = 1'b0;
    check("overrun_burst", overrun, 1);
    check("drop_count_burst", drop_count, 1);
    wait_outputs(5, 400);
    check("burst_exp_empty", exp_q.size(), 0);
    repeat (3) @(negedge clock);

    // Watchdog: filter never answers
    fir_silent = 1'b1;
    check("timeout_pre", timeout_err, 0);
    fx_q.push_back(8'd7);
    exp_q.push_back(8'd0);
    drive_one(8'd7, n);
    wait_outputs(1, 200);
    check("timeout_err", timeout_err, 1);
    check("timeout_latency", last_out_cyc, start_cyc + 65);
    @(negedge clock);
    @(negedge clock);
    check("timeout_idle", busy, 0);
    fir_silent = 1'b0;

    // Bypass: x=-5 passes straight through
    bypass  = 1'b1;
    starts0 = start_count;
    exp_q.push_back(8'hFB);
    drive_one(8'hFB, n);
    wait_outputs(1, 20);
    check("bypass_latency", last_out_cyc, n + 2);
    repeat (3) @(negedge clock);
    check("bypass_no_start", start_count, starts0);
    bypass = 1'b0;

    // Reset mid-WAIT abandons the sample
    fir_delay = 20;
    fx_q.push_back(8'd9);
    y_q.push_back(18'd5000);
    drive_one(8'd9, n);
    repeat (6) @(negedge clock);
    check("wait_busy", busy, 1);
    outs0 = out_count;
    #1 reset = 1'b1;
    #1;
    check("rst_mid_fir_x", fir_x, 0);
    check("rst_mid_out_sample", out_sample, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overrun", overrun, 0);
    check("rst_mid_timeout", timeout_err, 0);
    check("rst_mid_drop", drop_count, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("rst_no_out", out_count, outs0);
    check("rst_idle_busy", busy, 0);

    check("final_exp_empty", exp_q.size(), 0);
    check("final_fx_empty", fx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
